// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v scan counters, registered sync/blank/RGB
// outputs and a one-pixel-ahead request to the pixel source.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               enable,
  output logic               req,
  output logic [9:0]         req_x,
  output logic [9:0]         req_y,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] CLK_HI   = DW'((CLK_DIV + 1) / 2);

  typedef struct packed {
    logic               req;
    logic [9:0]         req_x;
    logic [9:0]         req_y;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               hs;
    logic               vs;
    logic               blank_n;
    logic               vga_clk;
    logic               frame_start;
  } out_t;

  localparam out_t OUT_RST = '{
    req: 1'b0, req_x: '0, req_y: '0, r: '0, g: '0, b: '0,
    hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0, vga_clk: 1'b0, frame_start: 1'b0
  };

  logic [DW-1:0] div, div_nxt;
  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic          parked;
  logic          tick, active, nxt_active, in_hs, in_vs;
  out_t          o;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    tick       = (div == DIV_LAST);
    div_nxt    = tick ? '0 : div + 1'b1;
    h_nxt      = (h == H_LAST) ? '0 : h + 1'b1;
    v_nxt      = v;
    if (h == H_LAST) v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
    active     = (h < H_ACT) && (v < V_ACT);
    nxt_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    in_hs      = (h >= H_SS) && (h < H_SE);
    in_vs      = (v >= V_SS) && (v < V_SE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div    <= '0;
      h      <= '0;
      v      <= '0;
      parked <= 1'b1;
      o      <= OUT_RST;
    end else if (!enable) begin
      div    <= '0;
      h      <= '0;
      v      <= '0;
      parked <= 1'b1;
      o      <= OUT_RST;
    end else begin
      o.req         <= 1'b0;
      o.frame_start <= 1'b0;
      if (parked) begin
        // Leaving park behaves like a tick: request (0,0) now, first real tick CLK_DIV later.
        parked    <= 1'b0;
        div       <= '0;
        o.vga_clk <= 1'b1;
        o.req     <= 1'b1;
        o.req_x   <= '0;
        o.req_y   <= '0;
      end else begin
        div       <= div_nxt;
        o.vga_clk <= (div_nxt < CLK_HI);
        if (tick) begin
          h             <= h_nxt;
          v             <= v_nxt;
          o.hs          <= in_hs ? HS_POL : ~HS_POL;
          o.vs          <= in_vs ? VS_POL : ~VS_POL;
          o.blank_n     <= active;
          o.r           <= active ? pix_r : '0;
          o.g           <= active ? pix_g : '0;
          o.b           <= active ? pix_b : '0;
          o.frame_start <= (h == '0) && (v == '0);
          if (nxt_active) begin
            o.req   <= 1'b1;
            o.req_x <= 10'(h_nxt);
            o.req_y <= 10'(v_nxt);
          end
        end
      end
    end
  end

  assign req         = o.req;
  assign req_x       = o.req_x;
  assign req_y       = o.req_y;
  assign VGA_R       = o.r;
  assign VGA_G       = o.g;
  assign VGA_B       = o.b;
  assign VGA_HS      = o.hs;
  assign VGA_VS      = o.vs;
  assign VGA_BLANK_N = o.blank_n;
  assign VGA_CLK     = o.vga_clk;
  assign frame_start = o.frame_start;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small configuration; a per-cycle scan model predicts
// timing outputs and a scoreboard carries requested pixels through to the DAC outputs.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 1, HSY = 2, HB = 1;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int DIV = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic       req;
  logic [9:0] req_x, req_y;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .CLK_DIV(DIV), .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(8)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .enable(enable),
    .req(req), .req_x(req_x), .req_y(req_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
    .VGA_SYNC_N(vga_sync_n), .VGA_CLK(vga_clk), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  int   total = 0;
  int   bad = 0;
  bit   run = 1'b0;
  int   k = 0;
  int   exp_rx = 0, exp_ry = 0;
  int   fs_count = 0;
  int   req_cnt = 0;
  bit   have_fs = 1'b0;
  pix_t sb[$];

  function automatic pix_t pix_of(int x, int y);
    pix_t p;
    p.r = x[7:0];
    p.g = y[7:0];
    p.b = {y[3:0], x[3:0]};
    return p;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_req"},   32'(req), 0);
    check({tag, "_hs"},    32'(vga_hs), 0);
    check({tag, "_vs"},    32'(vga_vs), 1);
    check({tag, "_blank"}, 32'(vga_blank_n), 0);
    check({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 0);
    check({tag, "_clk"},   32'(vga_clk), 0);
    check({tag, "_fs"},    32'(frame_start), 0);
    check({tag, "_xy"},    32'({req_x, req_y}), 0);
  endtask

  // One clock: advance the model, sample #1 after the edge, compare, then act as pixel source.
  task automatic cyc();
    int m, ph, p, h, v, nx, ny;
    bit e_req, e_fs, e_hs, e_vs, e_blank, e_clk;
    pix_t got, want;
    @(posedge clk);
    if (!rst_n || !enable) begin
      run = 1'b0;
      have_fs = 1'b0;
      sb.delete();
    end else if (!run) begin
      run = 1'b1;
      k = 0;
    end else begin
      k++;
    end
    #1;
    m = k / DIV;
    ph = k % DIV;
    e_req = 1'b0; e_fs = 1'b0; e_hs = 1'b0; e_vs = 1'b1; e_blank = 1'b0; e_clk = 1'b0;
    if (!run) begin
      exp_rx = 0;
      exp_ry = 0;
    end else begin
      e_clk = (ph < (DIV + 1) / 2);
      if (m >= 1) begin
        p = (m - 1) % FRAME;
        h = p % HT;
        v = p / HT;
        e_hs    = (h >= HA + HF) && (h < HA + HF + HSY);
        e_vs    = !((v >= VA + VF) && (v < VA + VF + VSY));
        e_blank = (h < HA) && (v < VA);
        e_fs    = (ph == 0) && (p == 0);
        if (ph == 0 && e_blank) begin
          check("sb_depth", 32'(sb.size()), 1);
          if (sb.size() > 0) begin
            want = sb.pop_front();
            got  = {vga_r, vga_g, vga_b};
            check("pixel", 32'(got), 32'(want));
          end
        end
      end
      if (ph == 0) begin
        nx = (m % FRAME) % HT;
        ny = (m % FRAME) / HT;
        if (nx < HA && ny < VA) begin
          e_req = 1'b1;
          exp_rx = nx;
          exp_ry = ny;
          sb.push_back(pix_of(nx, ny));
        end
      end
    end
    check("req",     32'(req), 32'(e_req));
    check("req_x",   32'(req_x), 32'(exp_rx));
    check("req_y",   32'(req_y), 32'(exp_ry));
    check("hs",      32'(vga_hs), 32'(e_hs));
    check("vs",      32'(vga_vs), 32'(e_vs));
    check("blank_n", 32'(vga_blank_n), 32'(e_blank));
    check("fs",      32'(frame_start), 32'(e_fs));
    check("vga_clk", 32'(vga_clk), 32'(e_clk));
    check("sync_n",  32'(vga_sync_n), 0);
    if (!e_blank) check("rgb_blank", 32'({vga_r, vga_g, vga_b}), 0);
    if (frame_start) begin
      fs_count++;
      if (have_fs) check("reqs_per_frame", 32'(req_cnt), HA * VA);
      have_fs = 1'b1;
      req_cnt = 0;
    end
    if (req) req_cnt++;
    if (req) begin
      pix_r = req_x[7:0];
      pix_g = req_y[7:0];
      pix_b = {req_y[3:0], req_x[3:0]};
    end else if (!run || ph == 0) begin
      pix_r = 8'hA5;
      pix_g = 8'hA5;
      pix_b = 8'hA5;
    end
  endtask

  initial begin
    // Reset held with clock running.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check_idle("reset");

    // Release: two full frames plus part of a third.
    rst_n = 1'b1;
    fs_count = 0;
    for (int i = 0; i < 2 * FRAME * DIV + 20; i++) cyc();
    check("fs_count_run1", 32'(fs_count), 3);

    // Drop enable mid-frame for 10 clocks, then restart from (0,0).
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check_idle("parked");
    enable = 1'b1;
    fs_count = 0;
    for (int i = 0; i < FRAME * DIV + 10; i++) cyc();
    check("fs_count_restart", 32'(fs_count), 2);

    // Asynchronous reset between edges: outputs return immediately.
    for (int i = 0; i < 40; i++) cyc();
    #3 rst_n = 1'b0;
    #1 check_idle("async_rst");
    for (int i = 0; i < 3; i++) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
